// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake/payload bundle for pipe_stage_reg.
//   master: drives advance, stall, flush, valid_in, halt_in, data_in;
//           observes data_out, valid_out, halt_out, busy, retire_cnt.
//   slave : the pipeline register itself (mirror directions).
// DATA_W and CNT_W must match the parameters of the attached pipe_stage_reg.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 32
);
   logic              advance;
   logic              stall;
   logic              flush;
   logic              valid_in;
   logic              halt_in;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              halt_out;
   logic              busy;
   logic [CNT_W-1:0]  retire_cnt;

   modport master (
      output advance, stall, flush, valid_in, halt_in, data_in,
      input  data_out, valid_out, halt_out, busy, retire_cnt
   );

   modport slave (
      input  advance, stall, flush, valid_in, halt_in, data_in,
      output data_out, valid_out, halt_out, busy, retire_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-stage pipeline register for an opaque payload between CPU stages.
// Per-stage valid/halt bits, stall/flush control, bubble insertion and a sticky halt latch.
//
// Ports:
//   CLK    - clock, all state updates on rising edge
//   nRST   - asynchronous active-low reset
//   io_bus - pipe_stage_reg_if.slave:
//              advance, stall, flush, valid_in, halt_in, data_in (inputs)
//              data_out, valid_out, halt_out, busy, retire_cnt (outputs)
//
// Optional feature macro: PIPE_STAGE_RETIRE_CNT_EN
//   defined   - saturating retire counter of entries delivered to the last stage
//   undefined - retire_cnt tied to 0, no counter flops
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned STAGES = 1,
   parameter int unsigned CNT_W  = 32
) (
   input  logic            CLK,
   input  logic            nRST,
   pipe_stage_reg_if.slave io_bus
);

   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("pipe_stage_reg: STAGES=%0d outside 1..4", STAGES);
      end
   endgenerate

   logic [DATA_W-1:0] r_data [STAGES];
   logic [STAGES-1:0] r_valid;
   logic [STAGES-1:0] r_halt;
   logic              r_halt_out;

   logic              w_shift;
   logic              w_in_valid;
   logic              w_in_halt;
   logic [DATA_W-1:0] w_in_data;
   logic              w_last_in_valid;
   logic              w_last_in_halt;
   logic              w_capture;
   logic              w_unused_halt_last;

   // Once halted the pipe freezes; only flush or reset may still touch the stages.
   assign w_shift    = io_bus.advance & ~io_bus.stall & ~r_halt_out;

   // A bubble carries neither payload nor halt.
   assign w_in_valid = io_bus.valid_in;
   assign w_in_halt  = io_bus.valid_in & io_bus.halt_in;
   assign w_in_data  = io_bus.valid_in ? io_bus.data_in : '0;

   // What the last stage would capture on a shift edge.
   generate
      if (STAGES == 1) begin : g_single
         assign w_last_in_valid = w_in_valid;
         assign w_last_in_halt  = w_in_halt;
      end else begin : g_multi
         assign w_last_in_valid = r_valid[STAGES-2];
         assign w_last_in_halt  = r_halt[STAGES-2];
      end
   endgenerate

   assign w_capture = w_shift & ~io_bus.flush & w_last_in_valid;

   // The last stage's halt bit is consumed at capture time by r_halt_out.
   assign w_unused_halt_last = r_halt[STAGES-1];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int k = 0; k < int'(STAGES); k++) r_data[k] <= '0;
         r_valid <= '0;
         r_halt  <= '0;
      end else if (io_bus.flush) begin
         for (int k = 0; k < int'(STAGES); k++) r_data[k] <= '0;
         r_valid <= '0;
         r_halt  <= '0;
      end else if (w_shift) begin
         r_data[0]  <= w_in_data;
         r_valid[0] <= w_in_valid;
         r_halt[0]  <= w_in_halt;
         for (int k = 1; k < int'(STAGES); k++) begin
            r_data[k]  <= r_data[k-1];
            r_valid[k] <= r_valid[k-1];
            r_halt[k]  <= r_halt[k-1];
         end
      end
   end

   // Sticky until reset; flush deliberately leaves it set.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_halt_out <= 1'b0;
      end else if (w_capture && w_last_in_halt) begin
         r_halt_out <= 1'b1;
      end
   end

`ifdef PIPE_STAGE_RETIRE_CNT_EN
   logic [CNT_W-1:0] r_retire_cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_retire_cnt <= '0;
      end else if (w_capture && (r_retire_cnt != {CNT_W{1'b1}})) begin
         r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign io_bus.retire_cnt = r_retire_cnt;
`else
   assign io_bus.retire_cnt = '0;
`endif

   assign io_bus.data_out  = r_data[STAGES-1];
   assign io_bus.valid_out = r_valid[STAGES-1];
   assign io_bus.halt_out  = r_halt_out;
   assign io_bus.busy      = |r_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg.
// Three instances: STAGES=1/CNT_W=4, STAGES=2, STAGES=3.
module tb_pipe_stage_reg;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   pipe_stage_reg_if #(.DATA_W(32), .CNT_W(4))  if1 ();
   pipe_stage_reg_if #(.DATA_W(32), .CNT_W(32)) if2 ();
   pipe_stage_reg_if #(.DATA_W(32), .CNT_W(32)) if3 ();

   pipe_stage_reg #(.DATA_W(32), .STAGES(1), .CNT_W(4))  u_dut1 (.CLK(CLK), .nRST(nRST), .io_bus(if1));
   pipe_stage_reg #(.DATA_W(32), .STAGES(2), .CNT_W(32)) u_dut2 (.CLK(CLK), .nRST(nRST), .io_bus(if2));
   pipe_stage_reg #(.DATA_W(32), .STAGES(3), .CNT_W(32)) u_dut3 (.CLK(CLK), .nRST(nRST), .io_bus(if3));

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct {
      logic        adv;
      logic        stall;
      logic        flush;
      logic        vin;
      logic        hin;
      logic [31:0] din;
      logic [31:0] e_data;
      logic        e_valid;
      logic        e_busy;
      int unsigned e_cnt;
   } vec_t;

   typedef struct {
      logic        adv;
      logic        stall;
      logic        vin;
      logic [31:0] din;
   } stim_t;

   typedef struct {
      logic [31:0] data;
      int unsigned due;
   } sb_t;

   vec_t        vecs[9];
   stim_t       s3[13];
   sb_t         sb[$];
   int unsigned sc3;
   int unsigned deliv3;
   logic        e3_valid;
   logic [31:0] e3_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected counter value: the counter only exists when the macro is defined.
   function automatic logic [63:0] ecnt(input int unsigned n);
`ifdef PIPE_STAGE_RETIRE_CNT_EN
      return 64'(n);
`else
      return 64'(n * 0);
`endif
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_all();
      if1.advance = 0; if1.stall = 0; if1.flush = 0; if1.valid_in = 0; if1.halt_in = 0;
      if1.data_in = '0;
      if2.advance = 0; if2.stall = 0; if2.flush = 0; if2.valid_in = 0; if2.halt_in = 0;
      if2.data_in = '0;
      if3.advance = 0; if3.stall = 0; if3.flush = 0; if3.valid_in = 0; if3.halt_in = 0;
      if3.data_in = '0;
   endtask

   task automatic drv2(input logic adv, input logic flush, input logic vin, input logic hin,
                       input logic [31:0] din);
      if2.advance = adv; if2.stall = 0; if2.flush = flush;
      if2.valid_in = vin; if2.halt_in = hin; if2.data_in = din;
      tick();
   endtask

   task automatic chk2(input string tag, input logic [31:0] data, input logic valid,
                       input logic busy, input logic halt, input int unsigned cnt);
      check({tag, "_data"},  64'(if2.data_out),   64'(data));
      check({tag, "_valid"}, 64'(if2.valid_out),  64'(valid));
      check({tag, "_busy"},  64'(if2.busy),       64'(busy));
      check({tag, "_halt"},  64'(if2.halt_out),   64'(halt));
      check({tag, "_cnt"},   64'(if2.retire_cnt), ecnt(cnt));
   endtask

   // One cycle of the STAGES=3 stream with scoreboard bookkeeping.
   task automatic cyc3(input int idx, input stim_t s);
      if3.advance = s.adv; if3.stall = s.stall; if3.flush = 0;
      if3.valid_in = s.vin; if3.halt_in = 0; if3.data_in = s.din;
      tick();
      if (s.adv && !s.stall) begin
         if (s.vin) sb.push_back('{data: s.din, due: sc3 + 3});
         sc3++;
         if (sb.size() > 0 && sb[0].due == sc3) begin
            e3_valid = 1'b1;
            e3_data  = sb[0].data;
            void'(sb.pop_front());
            deliv3++;
         end else begin
            e3_valid = 1'b0;
            e3_data  = '0;
         end
      end
      check($sformatf("s3_valid[%0d]", idx), 64'(if3.valid_out), 64'(e3_valid));
      check($sformatf("s3_data[%0d]", idx),  64'(if3.data_out),  64'(e3_data));
      check($sformatf("s3_busy[%0d]", idx),  64'(if3.busy),      64'((sb.size() != 0) | e3_valid));
      check($sformatf("s3_cnt[%0d]", idx),   64'(if3.retire_cnt), ecnt(deliv3));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            adv st fl vin hin din            e_data         ev eb cnt
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1, 1};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000001, 32'hDEADBEEF, 1'b1, 1'b1, 1};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000002, 32'hDEADBEEF, 1'b1, 1'b1, 1};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 1'b1, 1'b1, 2};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000AAAA, 32'h00000000, 1'b0, 1'b0, 2};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000055, 32'h00000055, 1'b1, 1'b1, 3};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 3};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000077, 32'h00000077, 1'b1, 1'b1, 4};

      //          adv   stall vin   din
      s3[0]  = '{1'b1, 1'b0, 1'b1, 32'h11};
      s3[1]  = '{1'b1, 1'b0, 1'b1, 32'h22};
      s3[2]  = '{1'b1, 1'b0, 1'b1, 32'h33};
      s3[3]  = '{1'b1, 1'b1, 1'b1, 32'h99};
      s3[4]  = '{1'b1, 1'b1, 1'b0, 32'h0};
      s3[5]  = '{1'b1, 1'b0, 1'b0, 32'h0};
      s3[6]  = '{1'b1, 1'b0, 1'b0, 32'h0};
      s3[7]  = '{1'b0, 1'b0, 1'b1, 32'hEE};
      s3[8]  = '{1'b1, 1'b0, 1'b1, 32'h44};
      s3[9]  = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF};
      s3[10] = '{1'b1, 1'b0, 1'b0, 32'h0};
      s3[11] = '{1'b1, 1'b0, 1'b0, 32'h0};
      s3[12] = '{1'b1, 1'b0, 1'b0, 32'h0};

      idle_all();
      nRST = 1'b0;
      repeat (2) tick();
      check("rst_d1_valid", 64'(if1.valid_out), 64'h0);
      check("rst_d1_data",  64'(if1.data_out),  64'h0);
      check("rst_d1_busy",  64'(if1.busy),      64'h0);
      check("rst_d2_halt",  64'(if2.halt_out),  64'h0);
      check("rst_d3_cnt",   64'(if3.retire_cnt), 64'h0);
      nRST = 1'b1;
      tick();

      // Single-stage behaviour, one vector per edge.
      for (int i = 0; i < 9; i++) begin
         if1.advance = vecs[i].adv; if1.stall = vecs[i].stall; if1.flush = vecs[i].flush;
         if1.valid_in = vecs[i].vin; if1.halt_in = vecs[i].hin; if1.data_in = vecs[i].din;
         tick();
         check($sformatf("v%0d_data", i),  64'(if1.data_out),   64'(vecs[i].e_data));
         check($sformatf("v%0d_valid", i), 64'(if1.valid_out),  64'(vecs[i].e_valid));
         check($sformatf("v%0d_busy", i),  64'(if1.busy),       64'(vecs[i].e_busy));
         check($sformatf("v%0d_halt", i),  64'(if1.halt_out),   64'h0);
         check($sformatf("v%0d_cnt", i),   64'(if1.retire_cnt), ecnt(vecs[i].e_cnt));
      end
      idle_all();

      // Three-stage stream with a two-cycle stall mid-stream.
      sc3 = 0; deliv3 = 0; e3_valid = 1'b0; e3_data = '0;
      for (int i = 0; i < 13; i++) begin
         cyc3(i, s3[i]);
         if (i == 2) check("s3_first_at_edge3", 64'(if3.data_out), 64'h11);
         if (i == 4) check("s3_held_in_stall",  64'(if3.data_out), 64'h11);
         if (i == 5) check("s3_second_slipped", 64'(if3.data_out), 64'h22);
         if (i == 6) check("s3_third_slipped",  64'(if3.data_out), 64'h33);
      end
      check("s3_sb_drained", 64'(sb.size()), 64'h0);
      idle_all();

      // Two-stage flush then halt.
      drv2(1, 0, 1, 0, 32'hA1);   chk2("f_e1", 32'h0, 0, 1, 0, 0);
      drv2(1, 0, 1, 0, 32'hB2);   chk2("f_e2", 32'hA1, 1, 1, 0, 1);
      drv2(1, 1, 1, 0, 32'hC3);   chk2("f_flush", 32'h0, 0, 0, 0, 1);
      drv2(0, 0, 0, 0, 32'h0);    chk2("f_after", 32'h0, 0, 0, 0, 1);
      drv2(1, 0, 1, 1, 32'h4A17); chk2("h_e1", 32'h0, 0, 1, 0, 1);
      drv2(1, 0, 1, 0, 32'h5);    chk2("h_e2", 32'h4A17, 1, 1, 1, 2);
      drv2(1, 0, 1, 0, 32'h6);    chk2("h_frz1", 32'h4A17, 1, 1, 1, 2);
      drv2(1, 0, 1, 0, 32'h7);    chk2("h_frz2", 32'h4A17, 1, 1, 1, 2);
      drv2(1, 1, 1, 0, 32'h8);    chk2("h_flush", 32'h0, 0, 0, 1, 2);
      drv2(1, 0, 1, 0, 32'h9);    chk2("h_post1", 32'h0, 0, 0, 1, 2);
      drv2(1, 0, 1, 0, 32'h9);    chk2("h_post2", 32'h0, 0, 0, 1, 2);
      idle_all();

      // Counter saturation on the 4-bit instance (4 already retired above).
      for (int i = 1; i <= 20; i++) begin
         if1.advance = 1; if1.valid_in = 1; if1.data_in = 32'(i);
         tick();
         check($sformatf("sat%0d_data", i), 64'(if1.data_out), 64'(i));
         check($sformatf("sat%0d_cnt", i), 64'(if1.retire_cnt),
               ecnt((4 + i > 15) ? 15 : 4 + i));
      end

      // Asynchronous reset between edges with traffic in flight.
      if3.advance = 1; if3.valid_in = 1; if3.data_in = 32'hCAFE;
      repeat (3) tick();
      check("ar_pre_valid", 64'(if3.valid_out), 64'h1);
      #2;
      nRST = 1'b0;
      #1;
      check("ar_d1_data",  64'(if1.data_out),   64'h0);
      check("ar_d1_valid", 64'(if1.valid_out),  64'h0);
      check("ar_d1_cnt",   64'(if1.retire_cnt), 64'h0);
      check("ar_d2_halt",  64'(if2.halt_out),   64'h0);
      check("ar_d2_cnt",   64'(if2.retire_cnt), 64'h0);
      check("ar_d3_data",  64'(if3.data_out),   64'h0);
      check("ar_d3_valid", 64'(if3.valid_out),  64'h0);
      check("ar_d3_busy",  64'(if3.busy),       64'h0);
      idle_all();
      tick();
      nRST = 1'b1;
      tick();
      check("ar_rel_d3_valid", 64'(if3.valid_out), 64'h0);

      // Halt cleared by reset: the two-stage pipe moves again.
      drv2(1, 0, 1, 0, 32'h600D); chk2("rr_e1", 32'h0, 0, 1, 0, 0);
      drv2(1, 0, 0, 0, 32'h0);    chk2("rr_e2", 32'h600D, 1, 1, 0, 1);
      idle_all();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed MEM/WB latch.
- Generic, multi-stage pipeline register carrying an opaque payload between CPU stages.
- Adds per-stage valid bits, stall/flush control, bubble insertion and a sticky halt latch.
- Drops in wherever a stage boundary is gated by cache hits (advance = ihit | dhit).

Parameters:
DATA_W, 32, payload width in bits (1..1024)
STAGES, 1, number of back-to-back register stages (1..4); values outside this range cause an elaboration $error
CNT_W, 32, width of retire counter

Ports:
CLK  input  1  clock, all state updates on rising edge
nRST  input  1  asynchronous active-low reset
advance  input  1  stage-advance enable (ihit | dhit)
stall  input  1  hazard hold; overrides advance
flush  input  1  squash all in-flight entries
valid_in  input  1  entry at data_in is a real instruction
halt_in  input  1  entry carries halt
data_in  input  DATA_W  payload
data_out  output  DATA_W  payload of last stage
valid_out  output  1  last stage holds a valid entry
halt_out  output  1  sticky: a valid halt entry has reached last stage
busy  output  1  OR of all stage valid bits
retire_cnt  output  CNT_W  count of valid entries delivered to last stage

Behaviour:
- Reset (nRST=0, asynchronous): all stage data=0, valid=0, halt bits=0, halt_out=0, busy=0, retire_cnt=0. Reset mid-operation discards all entries immediately.
- shift = advance & ~stall & ~halt_out.
- Priority per edge: reset > flush > shift > hold.
- Flush:
  - Acts on any edge, independent of advance/stall.
  - All stage valid bits, halt bits and data are cleared to 0.
  - halt_out and retire_cnt are NOT cleared.
- Shift:
  - Stage0 <= {valid_in, valid_in & halt_in, valid_in ? data_in : 0}; stage k <= stage k-1.
  - valid_in=0 inserts a bubble: all-zero data, no halt.
- Hold: all stages unchanged (stall=1, advance=0, or halt_out=1).
- Latency: an entry appears at data_out after exactly STAGES shift edges. Non-shift cycles add latency one-for-one.
- Outputs:
  - data_out/valid_out are direct register outputs of the last stage; no combinational path from inputs.
  - busy is combinational OR of stage valids.
- halt_out:
  - Set on the edge the last stage captures valid=1 and halt=1; stays 1 until reset.
  - While halt_out=1 the pipe freezes (shift suppressed); flush still clears stages.
- Simultaneous flush and shift: flush wins; the incoming entry is dropped.
- Simultaneous stall and advance: hold.

Optional Feature:
- Macro: PIPE_STAGE_RETIRE_CNT_EN.
- Defined:
  - retire_cnt increments by 1 on each edge where the last stage captures a valid entry (shift with stage STAGES-1 valid, no flush).
  - Saturates at 2^CNT_W-1; cleared only by reset.
- Undefined: retire_cnt tied to 0; no counter flops synthesised.

Test Plan:
1. Reset then STAGES=1: valid_in=1, data_in=0xDEADBEEF, advance=1 for one edge -> data_out=0xDEADBEEF, valid_out=1, busy=1, retire_cnt=1 (with macro).
2. STAGES=3, inject 0x11,0x22,0x33 on consecutive advance edges -> data_out=0x11 on third edge, 0x22, 0x33 on following edges; stall=1 for 2 cycles mid-stream -> data_out held, delivery slips by exactly 2 cycles.
3. STAGES=2, two valid entries in flight, flush=1 with advance=1 and valid_in=1 -> next cycle valid_out=0, data_out=0, busy=0; retire_cnt unchanged.
4. halt_in=1 with valid_in=1, STAGES=2 -> halt_out=1 after second advance edge; further advance edges with new data leave data_out unchanged; only nRST=0 clears halt_out.
5. valid_in=0, data_in=0xFFFFFFFF, advance=1 -> stage captures data 0, valid_out=0 after latency, retire_cnt not incremented.
6. CNT_W=4, 20 valid deliveries (macro on) -> retire_cnt saturates at 15; assert nRST mid-stream -> all outputs 0 asynchronously before next edge.
